imem_ld: RTL and testbench

IMEM_LD -- requirements
Module: imem_ld

---
 rtl/imem_ld.sv | 198 +++++++++++++++++++
 tb/tb_imem_ld.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ld.sv
`default_nettype none
// ============================================================================
// Module   : imem_ld
// Purpose  : Loadable instruction memory. A program is streamed in word by
//            word (LOAD), after which single-cycle-latency fetches are served
//            at up to one per cycle (RUN). Fetches beyond DEPTH return FILL
//            and flag fetch_err. Memory contents survive reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   clear        in   asynchronous active-low reset
//   fetch_valid  in   fetch request present
//   address      in   fetch address [ADDR_W]
//   fetch_ready  out  fetch can be accepted (RUN)
//   instruction  out  registered fetch result [DATA_W]
//   instr_valid  out  one-cycle pulse per accepted fetch
//   fetch_err    out  result came from an out-of-range address
//   load_start   in   begin program load at word 0
//   load_valid   in   load_data holds a word
//   load_data    in   program word [DATA_W]
//   load_last    in   final word of the program
//   load_ready   out  load word can be accepted (LOAD)
//   load_ovf     out  sticky: word arrived beyond DEPTH-1
//   load_count   out  words written in current/last load [ADDR_W+1]
// ============================================================================
module imem_ld #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       DEPTH  = 32,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] address,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_ovf,
  output logic [ADDR_W:0]   load_count
);

  // Storage index width; DEPTH <= 2^ADDR_W guarantees c_IDX_W <= ADDR_W.
  localparam int unsigned     c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_room;
  logic                w_wr_en;
  logic                w_fetch_acc;
  logic                w_addr_oor;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;

  assign w_room     = (count_q < c_DEPTH);
  assign w_addr_oor = ({1'b0, address} >= c_DEPTH);
  assign w_wr_idx   = count_q[c_IDX_W-1:0];
  assign w_rd_idx   = address[c_IDX_W-1:0];

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    w_wr_en     = 1'b0;
    w_fetch_acc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end

      LOAD: begin
        // load_start is deliberately not looked at here.
        if (load_valid) begin
          if (w_room) begin
            w_wr_en = 1'b1;
            count_d = count_q + c_ONE;
          end else begin
            // Memory full: drop the word but keep consuming until load_last.
            ovf_d = 1'b1;
          end
          if (load_last) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // A reload request wins; a fetch presented in the same cycle is lost.
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          w_fetch_acc = fetch_valid;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch result path: instruction/fetch_err hold between results,
  // instr_valid pulses for exactly one cycle per accepted fetch.
  // --------------------------------------------------------------------------
  always_comb begin
    instr_d = instr_q;
    err_d   = err_q;
    valid_d = w_fetch_acc;
    if (w_fetch_acc) begin
      if (w_addr_oor) begin
        instr_d = FILL;
        err_d   = 1'b1;
      end else begin
        // Words at or beyond load_count are legal and may be stale.
        instr_d = mem_q[w_rd_idx];
        err_d   = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Program storage. Not reset, so a load interrupted by clear leaves the
  // words already written in place.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_idx] <= load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fetch_ready = (state_q == RUN);
  assign load_ready  = (state_q == LOAD);
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign load_ovf    = ovf_q;
  assign load_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_ld.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_ld
// Purpose  : Self-checking bench for imem_ld. Expected fetch results are
//            pushed to a queue when a fetch is driven and popped when the
//            result is due one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_ld;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              clear;
  logic              fetch_valid;
  logic [ADDR_W-1:0] address;
  logic              fetch_ready;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fetch_err;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_ovf;
  logic [ADDR_W:0]   load_count;

  always #5 clk = ~clk;

  imem_ld #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .FILL  (8'h00)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .fetch_valid(fetch_valid),
    .address    (address),
    .fetch_ready(fetch_ready),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_ovf   (load_ovf),
    .load_count (load_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory image and load pointer, driven only by stimulus.
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int                mdl_cnt = 0;
  // Scoreboard entries: {fetch_err, instruction}.
  logic [DATA_W:0]   exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mdl_cnt    = 0;
  endtask

  task automatic drive_word(input logic [DATA_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (mdl_cnt < DEPTH) mdl_mem[mdl_cnt] = d;
    mdl_cnt++;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Queue the expected result of a fetch from address a.
  task automatic push_exp(input logic [ADDR_W-1:0] a);
    if (a >= DEPTH) exp_q.push_back({1'b1, 8'h00});
    else            exp_q.push_back({1'b0, mdl_mem[a[4:0]]});
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (instruction !== 8'h00) begin bad++; $display("FAIL rst_instruction got=%h want=00", instruction); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b want=0", instr_valid); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_fetch_err got=%b want=0", fetch_err); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_fetch_ready got=%b want=0", fetch_ready); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready got=%b want=0", load_ready); end
    total++; if (load_count !== 9'd0) begin bad++; $display("FAIL rst_load_count got=%0d want=0", load_count); end
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL rst_load_ovf got=%b want=0", load_ovf); end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_load();
    logic [DATA_W-1:0] prog [11];
    prog = '{8'h49, 8'h27, 8'h39, 8'h18, 8'h07, 8'h32, 8'h2D, 8'h18, 8'h4D, 8'h1E, 8'hC3};
    start_load();
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_in_load got=%b want=1", load_ready); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL fetch_ready_in_load got=%b want=0", fetch_ready); end
    for (int i = 0; i < 11; i++) drive_word(prog[i], (i == 10));
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL load_run_fetch_ready got=%b want=1", fetch_ready); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL load_run_load_ready got=%b want=0", load_ready); end
    total++; if (load_count !== 9'd11) begin bad++; $display("FAIL load_count11 got=%0d want=11", load_count); end
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL load_ovf11 got=%b want=0", load_ovf); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] seq [5];
    logic [DATA_W:0]   e;
    seq = '{8'd0, 8'd1, 8'd10, 8'd3, 8'd7};
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1;
      address     = seq[i];
      push_exp(seq[i]);
      tick();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instruction !== e[7:0] || fetch_err !== e[8]) begin
          bad++;
          $display("FAIL b2b[%0d] valid=%b instr=%h err=%b want valid=1 instr=%h err=%b",
                   i, instr_valid, instruction, fetch_err, e[7:0], e[8]);
        end
      end
    end
    fetch_valid = 1'b0;
    tick();
    total++;
    if (instr_valid !== 1'b0 || instruction !== mdl_mem[7] || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold valid=%b instr=%h err=%b want valid=0 instr=%h err=0",
               instr_valid, instruction, fetch_err, mdl_mem[7]);
    end
  endtask

  task automatic test_out_of_range();
    logic [ADDR_W-1:0] seq [4];
    logic [DATA_W:0]   e;
    seq = '{8'd2, 8'd32, 8'd255, 8'd31 + 8'd1};
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1;
      address     = seq[i];
      push_exp(seq[i]);
      tick();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL oor_sb_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instruction !== e[7:0] || fetch_err !== e[8]) begin
          bad++;
          $display("FAIL oor[%0d] valid=%b instr=%h err=%b want valid=1 instr=%h err=%b",
                   i, instr_valid, instruction, fetch_err, e[7:0], e[8]);
        end
      end
    end
    fetch_valid = 1'b0;
    tick();
    total++;
    if (instr_valid !== 1'b0 || instruction !== 8'h00 || fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL oor_hold valid=%b instr=%h err=%b want valid=0 instr=00 err=1",
               instr_valid, instruction, fetch_err);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W:0] e;
    logic [ADDR_W-1:0] seq [3];
    seq = '{8'd31, 8'd0, 8'd32};
    start_load();
    for (int i = 0; i < 32; i++) drive_word(8'(8'h80 + i), 1'b0);
    total++; if (load_count !== 9'd32) begin bad++; $display("FAIL ovf_full_count got=%0d want=32", load_count); end
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL ovf_full_flag got=%b want=0", load_ovf); end
    drive_word(8'hA0, 1'b0);
    total++; if (load_ovf !== 1'b1) begin bad++; $display("FAIL ovf_33_flag got=%b want=1", load_ovf); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ovf_33_still_load got=%b want=1", load_ready); end
    drive_word(8'hA1, 1'b1);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL ovf_run got=%b want=1", fetch_ready); end
    total++; if (load_count !== 9'd32) begin bad++; $display("FAIL ovf_count got=%0d want=32", load_count); end
    total++; if (load_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", load_ovf); end
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1;
      address     = seq[i];
      push_exp(seq[i]);
      tick();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL ovf_sb_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instruction !== e[7:0] || fetch_err !== e[8]) begin
          bad++;
          $display("FAIL ovf_fetch[%0d] valid=%b instr=%h err=%b want valid=1 instr=%h err=%b",
                   i, instr_valid, instruction, fetch_err, e[7:0], e[8]);
        end
      end
    end
    fetch_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    logic [DATA_W:0] e;
    logic [ADDR_W-1:0] seq [3];
    seq = '{8'd1, 8'd5, 8'd40};
    // Reload request and fetch in the same cycle: the fetch must vanish.
    fetch_valid = 1'b1;
    address     = 8'd0;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
    fetch_valid = 1'b0;
    mdl_cnt     = 0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL prio_no_valid got=%b want=0", instr_valid); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL prio_load got=%b want=1", load_ready); end
    total++; if (load_count !== 9'd0) begin bad++; $display("FAIL prio_count got=%0d want=0", load_count); end
    total++; if (load_ovf !== 1'b0) begin bad++; $display("FAIL prio_ovf_clr got=%b want=0", load_ovf); end
    // load_start asserted while loading must not restart the count.
    load_start = 1'b1;
    drive_word(8'h11, 1'b0);
    drive_word(8'h22, 1'b0);
    load_start = 1'b0;
    total++; if (load_count !== 9'd2) begin bad++; $display("FAIL start_ignored got=%0d want=2", load_count); end
    drive_word(8'h33, 1'b1);
    total++; if (load_count !== 9'd3 || fetch_ready !== 1'b1) begin bad++; $display("FAIL reload_run count=%0d rdy=%b want count=3 rdy=1", load_count, fetch_ready); end
    // Address 5 is beyond load_count but in range: stale word from before.
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1;
      address     = seq[i];
      push_exp(seq[i]);
      tick();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL prio_sb_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instruction !== e[7:0] || fetch_err !== e[8]) begin
          bad++;
          $display("FAIL prio_fetch[%0d] valid=%b instr=%h err=%b want valid=1 instr=%h err=%b",
                   i, instr_valid, instruction, fetch_err, e[7:0], e[8]);
        end
      end
    end
    fetch_valid = 1'b0;
    // Leave a non-reset value in instruction so the reset test sees a change.
    fetch_valid = 1'b1;
    address     = 8'd0;
    push_exp(8'd0);
    tick();
    fetch_valid = 1'b0;
    total++;
    e = exp_q.pop_front();
    if (instr_valid !== 1'b1 || instruction !== e[7:0]) begin
      bad++;
      $display("FAIL prio_fetch0 valid=%b instr=%h want valid=1 instr=%h", instr_valid, instruction, e[7:0]);
    end
  endtask

  task automatic test_reset_midload();
    logic [DATA_W:0] e;
    logic [ADDR_W-1:0] seq [2];
    seq = '{8'd3, 8'd0};
    start_load();
    for (int i = 0; i < 5; i++) drive_word(8'(8'hB0 + i), 1'b0);
    total++; if (load_count !== 9'd5) begin bad++; $display("FAIL mid_count got=%0d want=5", load_count); end
    #2;
    clear = 1'b0;
    #1;
    total++;
    if (instruction !== 8'h00 || instr_valid !== 1'b0 || fetch_err !== 1'b0 ||
        fetch_ready !== 1'b0 || load_ready !== 1'b0 || load_count !== 9'd0 || load_ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_rst instr=%h iv=%b err=%b frdy=%b lrdy=%b cnt=%0d ovf=%b want all zero",
               instruction, instr_valid, fetch_err, fetch_ready, load_ready, load_count, load_ovf);
    end
    #1;
    clear = 1'b1;
    // Without a fresh load_start nothing may happen.
    load_valid  = 1'b1;
    load_last   = 1'b1;
    load_data   = 8'hEE;
    fetch_valid = 1'b1;
    address     = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fetch_ready !== 1'b0 || load_ready !== 1'b0 || instr_valid !== 1'b0 || load_count !== 9'd0) begin
        bad++;
        $display("FAIL idle_hold[%0d] frdy=%b lrdy=%b iv=%b cnt=%0d want 0 0 0 0",
                 i, fetch_ready, load_ready, instr_valid, load_count);
      end
    end
    load_valid  = 1'b0;
    load_last   = 1'b0;
    fetch_valid = 1'b0;
    start_load();
    drive_word(8'h5A, 1'b1);
    total++; if (fetch_ready !== 1'b1 || load_count !== 9'd1) begin bad++; $display("FAIL relaunch rdy=%b cnt=%0d want rdy=1 cnt=1", fetch_ready, load_count); end
    for (int i = 0; i < 2; i++) begin
      fetch_valid = 1'b1;
      address     = seq[i];
      push_exp(seq[i]);
      tick();
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL mid_sb_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instruction !== e[7:0] || fetch_err !== e[8]) begin
          bad++;
          $display("FAIL mid_fetch[%0d] valid=%b instr=%h err=%b want valid=1 instr=%h err=%b",
                   i, instr_valid, instruction, fetch_err, e[7:0], e[8]);
        end
      end
    end
    fetch_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear       = 1'b0;
    fetch_valid = 1'b0;
    address     = '0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    test_reset();
    test_load();
    test_back_to_back();
    test_out_of_range();
    test_overflow();
    test_load_priority();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
